regfile_gpr: RTL and testbench
==============================

Name: regfile_gpr

Overview:
- 32-entry general-purpose register file for the RV32I core; it is the responder for the decoder's two read-address requests.
- The decoder drives rs1/rs2 addresses and consumes the returned data in the same cycle. The writeback stage drives the single write port.
- After reset, a clear sequencer zeroes the array one entry per cycle.
- A debug access port gives read/write access with a request/ack handshake.

Parameters:
NUM_REGS, 32, number of architectural registers (entry 0 hardwired to zero)
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
rd1_addr_i  in  ADDR_W  read port 1 address (rs1 from decoder)
rd1_data_o  out  DATA_W  read port 1 data, combinational
rd2_addr_i  in  ADDR_W  read port 2 address (rs2 from decoder)
rd2_data_o  out  DATA_W  read port 2 data, combinational
wr_en_i  in  1  writeback write enable
wr_addr_i  in  ADDR_W  writeback destination (rd)
wr_data_i  in  DATA_W  writeback data
dbg_en_i  in  1  debug request, held until ack
dbg_we_i  in  1  debug request is a write
dbg_addr_i  in  ADDR_W  debug register address
dbg_wdata_i  in  DATA_W  debug write data
dbg_rdata_o  out  DATA_W  debug read data, registered, valid while dbg_ack_o=1
dbg_ack_o  out  1  one-cycle pulse: debug request complete
init_busy_o  out  1  high while the clear sequencer runs

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). No other reset or clock.
- FSM states:
  - INIT: clear sequencer running.
  - RUN: normal operation.
  - DBG_RESP: debug ack cycle.
- Reset (rst=1 at posedge):
  - state<=INIT, clear counter<=0, dbg_ack_o<=0, dbg_rdata_o<=0, init_busy_o=1.
  - Array contents are not touched while rst is held.
  - Reset mid-debug-transaction drops the ack and returns to INIT.
- INIT:
  - Each cycle, entry[cnt]<=0 and cnt<=cnt+1.
  - At cnt==NUM_REGS-1, go to RUN next cycle. init_busy_o is high for exactly NUM_REGS cycles after rst deasserts.
  - wr_en_i and dbg_en_i are ignored (writes dropped, no ack).
  - rd1_data_o/rd2_data_o are forced to 0.
- Read ports (RUN and DBG_RESP), evaluated per port:
  - addr==0 -> 0.
  - Otherwise, if wr_en_i && wr_addr_i==addr -> wr_data_i (write-through bypass, same cycle).
  - Otherwise -> array[addr].
- Write port (RUN and DBG_RESP): if wr_en_i && wr_addr_i!=0, array[wr_addr_i]<=wr_data_i at posedge. Writes to x0 are discarded.
- Debug handshake, in RUN when dbg_en_i=1:
  - Write with wr_en_i=1 in the same cycle: core write has priority. The debug request stalls in RUN (no ack) and is retried next cycle.
  - Write otherwise: array[dbg_addr_i]<=dbg_wdata_i (discarded if addr 0). Go to DBG_RESP.
  - Read: dbg_rdata_o<=value by the read-port rule (bypass included, addr 0 ->0). Go to DBG_RESP.
- DBG_RESP:
  - dbg_ack_o=1 for this cycle only; next state is RUN.
  - Core writes still proceed.
  - dbg_en_i sampled here is not a new request. If still high in the following RUN cycle, it is a new request.
- Latency:
  - Read ports: 0 cycles.
  - Write visible to the array next cycle, and in the same cycle via bypass.
  - Debug: ack 1 cycle after acceptance, so minimum 2-cycle request-to-request spacing.
- Simultaneous events:
  - Core and debug write to the same address in one cycle: the core write wins and the debug write is retried the next cycle, so final value = debug data.
  - Both read ports may address the same register.
- dbg_rdata_o holds its last value outside ack cycles.

Test Plan:
- Reset sequence:
  - Pulse rst 2 cycles.
  - init_busy_o=1 for 32 cycles after release; during INIT, wr_en_i=1 to x5 with 0xDEADBEEF is ignored.
  - After INIT, all regs read 0.
- Write/read with bypass:
  - Write x3=0x12345678 with rd1_addr_i=3 in the same cycle -> rd1_data_o=0x12345678 that cycle.
  - Next cycle, with wr_en_i=0 -> still 0x12345678.
- x0 handling:
  - Write x0=0xFFFFFFFF with rd1_addr_i=rd2_addr_i=0 -> both read 0 that cycle and after.
  - Debug read of x0 -> dbg_rdata_o=0.
- Debug/core collision:
  - Same cycle: dbg write x7=0xAAAA0000 and core write x7=0x5555.
  - Response: no ack that cycle; ack one cycle later than normal; x7 finally reads 0xAAAA0000.
- Debug read with bypass:
  - x9=0x1, then dbg read x9 while core writes x9=0x2 in the same cycle.
  - Response: next cycle dbg_ack_o=1 for one cycle with dbg_rdata_o=0x2.
- Reset mid-operation:
  - Assert rst in the DBG_RESP cycle.
  - Response: dbg_ack_o=0 next cycle; INIT reruns for 32 cycles; previously written x3 reads 0 afterwards.

Source files
------------

// File: rtl/regfile_gpr_if.sv
// Bundle of the decoder read ports, writeback write port and debug access port
// for the general-purpose register file.
interface regfile_gpr_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] rd1_addr;
  logic [DATA_W-1:0] rd1_data;
  logic [ADDR_W-1:0] rd2_addr;
  logic [DATA_W-1:0] rd2_data;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic              dbg_en;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_ack;

  logic              init_busy;

  modport master (
    output rd1_addr, rd2_addr, wr_en, wr_addr, wr_data,
           dbg_en, dbg_we, dbg_addr, dbg_wdata,
    input  rd1_data, rd2_data, dbg_rdata, dbg_ack, init_busy
  );

  modport slave (
    input  rd1_addr, rd2_addr, wr_en, wr_addr, wr_data,
           dbg_en, dbg_we, dbg_addr, dbg_wdata,
    output rd1_data, rd2_data, dbg_rdata, dbg_ack, init_busy
  );
endinterface

// File: rtl/regfile_gpr.sv
// RV32I register file: two combinational read ports with write-through bypass,
// one write port, post-reset clear sequencer and a request/ack debug port.
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   S_INIT     | clear sequencer zeroing one entry per cycle
//   S_RUN      | normal operation, debug requests accepted
//   S_DBG_RESP | debug ack cycle
module regfile_gpr #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5
) (
  input  logic         clk,
  input  logic         rst,
  regfile_gpr_if.slave bus
);

  localparam logic [1:0] S_INIT     = 2'd0;
  localparam logic [1:0] S_RUN      = 2'd1;
  localparam logic [1:0] S_DBG_RESP = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;
  logic [DATA_W-1:0] mem [NUM_REGS];

  logic              in_init;
  logic              core_we;
  logic              dbg_go;
  logic              dbg_wr_go;
  logic [DATA_W-1:0] rd1_val;
  logic [DATA_W-1:0] rd2_val;
  logic [DATA_W-1:0] dbg_val;

  assign in_init = (state == S_INIT);
  assign core_we = !in_init && bus.wr_en && (bus.wr_addr != '0);

  // Any core write in the same cycle stalls a debug write, regardless of address.
  assign dbg_go    = (state == S_RUN) && bus.dbg_en && !(bus.dbg_we && bus.wr_en);
  assign dbg_wr_go = dbg_go && bus.dbg_we;

  always_comb begin
    rd1_val = '0;
    if (!in_init && bus.rd1_addr != '0) begin
      if (bus.wr_en && bus.wr_addr == bus.rd1_addr) rd1_val = bus.wr_data;
      else                                          rd1_val = mem[bus.rd1_addr];
    end
  end

  always_comb begin
    rd2_val = '0;
    if (!in_init && bus.rd2_addr != '0) begin
      if (bus.wr_en && bus.wr_addr == bus.rd2_addr) rd2_val = bus.wr_data;
      else                                          rd2_val = mem[bus.rd2_addr];
    end
  end

  always_comb begin
    dbg_val = '0;
    if (bus.dbg_addr != '0) begin
      if (bus.wr_en && bus.wr_addr == bus.dbg_addr) dbg_val = bus.wr_data;
      else                                          dbg_val = mem[bus.dbg_addr];
    end
  end

  // Array has no reset; it is cleared by the sequencer once rst is released.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (in_init) begin
        mem[cnt] <= '0;
      end else begin
        if (core_we)
          mem[bus.wr_addr] <= bus.wr_data;
        if (dbg_wr_go && bus.dbg_addr != '0)
          mem[bus.dbg_addr] <= bus.dbg_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_INIT;
      cnt       <= '0;
      dbg_ack   <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      dbg_ack <= 1'b0;
      case (state)
        S_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_IDX) state <= S_RUN;
        end
        S_RUN: begin
          if (dbg_go) begin
            state   <= S_DBG_RESP;
            dbg_ack <= 1'b1;
            if (!bus.dbg_we) dbg_rdata <= dbg_val;
          end
        end
        S_DBG_RESP: state <= S_RUN;
        default:    state <= S_INIT;
      endcase
    end
  end

  assign bus.rd1_data  = rd1_val;
  assign bus.rd2_data  = rd2_val;
  assign bus.dbg_ack   = dbg_ack;
  assign bus.dbg_rdata = dbg_rdata;
  assign bus.init_busy = in_init;

endmodule

// File: tb/tb_regfile_gpr.sv
// Directed bench for regfile_gpr: reset/clear, bypass, x0, debug port corners.
module tb_regfile_gpr;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_gpr_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  regfile_gpr #(.NUM_REGS(32), .DATA_W(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rd1_addr  = '0;
    bus.rd2_addr  = '0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.dbg_en    = 1'b0;
    bus.dbg_we    = 1'b0;
    bus.dbg_addr  = '0;
    bus.dbg_wdata = '0;
  endtask

  task automatic core_write(input logic [4:0] a, input logic [31:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  // Issue a debug request and count cycles until ack; bounded.
  task automatic dbg_xfer(input logic we, input logic [4:0] a, input logic [31:0] d,
                          output logic [31:0] rdata, output int lat);
    bus.dbg_en    = 1'b1;
    bus.dbg_we    = we;
    bus.dbg_addr  = a;
    bus.dbg_wdata = d;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus.dbg_ack && lat < 8);
    rdata = bus.dbg_rdata;
    bus.dbg_en = 1'b0;
  endtask

  // Counts cycles init_busy stays high; injects ignored traffic meanwhile.
  task automatic run_init(input string tag);
    int n;
    int acks;
    n    = 0;
    acks = 0;
    bus.wr_en    = 1'b1;
    bus.wr_addr  = 5'd5;
    bus.wr_data  = 32'hDEADBEEF;
    bus.rd1_addr = 5'd5;
    bus.dbg_en   = 1'b1;
    bus.dbg_we   = 1'b0;
    bus.dbg_addr = 5'd5;
    #1;
    check({tag, "_rd_forced0"}, bus.rd1_data, 32'h0);
    while (bus.init_busy && n < 100) begin
      if (bus.dbg_ack) acks++;
      n++;
      tick();
    end
    idle_inputs();
    check({tag, "_busy_cycles"}, n, 32);
    check({tag, "_no_ack"}, acks, 0);
  endtask

  logic [31:0] rd;
  int          lat;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    check("rst_busy", bus.init_busy, 1'b1);
    check("rst_ack", bus.dbg_ack, 1'b0);
    check("rst_rdata", bus.dbg_rdata, 32'h0);
    rst = 1'b0;
    run_init("init1");

    for (int i = 0; i < 32; i++) begin
      bus.rd1_addr = 5'(i);
      bus.rd2_addr = 5'(31 - i);
      #1;
      check($sformatf("clr_rd1_x%0d", i), bus.rd1_data, 32'h0);
      check($sformatf("clr_rd2_x%0d", 31 - i), bus.rd2_data, 32'h0);
    end

    bus.wr_en    = 1'b1;
    bus.wr_addr  = 5'd3;
    bus.wr_data  = 32'h12345678;
    bus.rd1_addr = 5'd3;
    bus.rd2_addr = 5'd3;
    #1;
    check("bypass_rd1", bus.rd1_data, 32'h12345678);
    check("bypass_rd2", bus.rd2_data, 32'h12345678);
    tick();
    bus.wr_en = 1'b0;
    #1;
    check("array_rd1_x3", bus.rd1_data, 32'h12345678);

    bus.wr_en    = 1'b1;
    bus.wr_addr  = 5'd0;
    bus.wr_data  = 32'hFFFFFFFF;
    bus.rd1_addr = 5'd0;
    bus.rd2_addr = 5'd0;
    #1;
    check("x0_bypass_rd1", bus.rd1_data, 32'h0);
    check("x0_bypass_rd2", bus.rd2_data, 32'h0);
    tick();
    bus.wr_en = 1'b0;
    #1;
    check("x0_after_rd1", bus.rd1_data, 32'h0);
    check("x0_after_rd2", bus.rd2_data, 32'h0);

    dbg_xfer(1'b0, 5'd3, 32'h0, rd, lat);
    check("dbg_rd_x3_lat", lat, 1);
    check("dbg_rd_x3_data", rd, 32'h12345678);
    tick();
    check("dbg_ack_pulse", bus.dbg_ack, 1'b0);
    dbg_xfer(1'b0, 5'd0, 32'h0, rd, lat);
    check("dbg_rd_x0_data", rd, 32'h0);
    tick();

    dbg_xfer(1'b1, 5'd12, 32'hCAFEF00D, rd, lat);
    check("dbg_wr_lat", lat, 1);
    tick();
    bus.rd2_addr = 5'd12;
    #1;
    check("dbg_wr_x12", bus.rd2_data, 32'hCAFEF00D);

    bus.dbg_en    = 1'b1;
    bus.dbg_we    = 1'b1;
    bus.dbg_addr  = 5'd7;
    bus.dbg_wdata = 32'hAAAA0000;
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 5'd7;
    bus.wr_data   = 32'h00005555;
    tick();
    bus.wr_en = 1'b0;
    check("coll_no_ack", bus.dbg_ack, 1'b0);
    tick();
    check("coll_late_ack", bus.dbg_ack, 1'b1);
    bus.dbg_en = 1'b0;
    tick();
    check("coll_ack_drop", bus.dbg_ack, 1'b0);
    bus.rd1_addr = 5'd7;
    #1;
    check("coll_x7", bus.rd1_data, 32'hAAAA0000);

    core_write(5'd9, 32'h1);
    bus.dbg_en   = 1'b1;
    bus.dbg_we   = 1'b0;
    bus.dbg_addr = 5'd9;
    bus.wr_en    = 1'b1;
    bus.wr_addr  = 5'd9;
    bus.wr_data  = 32'h2;
    tick();
    bus.wr_en  = 1'b0;
    check("dbg_byp_ack", bus.dbg_ack, 1'b1);
    check("dbg_byp_data", bus.dbg_rdata, 32'h2);
    bus.dbg_en = 1'b0;
    tick();
    check("dbg_byp_ack_drop", bus.dbg_ack, 1'b0);
    check("dbg_rdata_hold", bus.dbg_rdata, 32'h2);
    bus.rd1_addr = 5'd9;
    #1;
    check("x9_after", bus.rd1_data, 32'h2);

    bus.dbg_en   = 1'b1;
    bus.dbg_we   = 1'b0;
    bus.dbg_addr = 5'd3;
    tick();
    check("mid_ack", bus.dbg_ack, 1'b1);
    rst = 1'b1;
    tick();
    check("mid_rst_ack", bus.dbg_ack, 1'b0);
    check("mid_rst_rdata", bus.dbg_rdata, 32'h0);
    check("mid_rst_busy", bus.init_busy, 1'b1);
    rst = 1'b0;
    run_init("init2");
    bus.rd1_addr = 5'd3;
    bus.rd2_addr = 5'd7;
    #1;
    check("reinit_x3", bus.rd1_data, 32'h0);
    check("reinit_x7", bus.rd2_data, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
